// File: rtl/regfile_pkg.sv
// Register file constants shared by the regfile, decode and the late
// write-back queue.
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wbq_storage.sv
// Entry array for the late write-back queue: one write port at tail,
// one read port at head, all entries exposed for forwarding.
module wbq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 37,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      we,
  input  logic [PW-1:0]             waddr,
  input  logic [W-1:0]              wdata,
  input  logic                      re,
  input  logic [PW-1:0]             raddr,
  output logic [W-1:0]              rdata,
  output logic [DEPTH-1:0][W-1:0]   entries,
  output logic [DEPTH-1:0]          valid
);

  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // head and tail only coincide when empty or full, so re/we never collide
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      valid <= '0;
    end else begin
      if (re) valid[raddr] <= 1'b0;
      if (we) valid[waddr] <= 1'b1;
    end
  end

  assign rdata   = mem[raddr];
  assign entries = mem;

endmodule

// File: rtl/regfile_write_queue.sv
// Late write-back queue: drains multdiv/memory results into the shared
// regfile write port when the main writeback is idle, and forwards them.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_reg,
  input  logic [DW-1:0]            in_data,
  input  logic                     rf_busy,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_reg,
  output logic [DW-1:0]            wr_data,
  input  logic [AW-1:0]            rd_regA,
  input  logic [AW-1:0]            rd_regB,
  output logic                     fwd_hitA,
  output logic                     fwd_hitB,
  output logic [DW-1:0]            fwd_dataA,
  output logic [DW-1:0]            fwd_dataB,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic [EW-1:0]          head_entry;
  logic [DEPTH-1:0][EW-1:0] entries;
  logic [DEPTH-1:0]       valid;

  assign in_ready = (count < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_reg != AW'(REG_ZERO));
  assign pop      = (count != '0) && !rf_busy;

  wbq_storage #(
    .DEPTH (DEPTH),
    .W     (EW),
    .PW    (PW)
  ) u_storage (
    .clk     (clk),
    .clr_n   (clr_n),
    .we      (push),
    .waddr   (tail),
    .wdata   ({in_reg, in_data}),
    .re      (pop),
    .raddr   (head),
    .rdata   (head_entry),
    .entries (entries),
    .valid   (valid)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      wr_en <= pop;
      if (pop) begin
        wr_reg  <= head_entry[EW-1:DW];
        wr_data <= head_entry[DW-1:0];
      end
    end
  end

  // Walk oldest to youngest so the last match wins.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] rd);
    logic          hit;
    logic [DW-1:0] d;
    logic [PW-1:0] idx;
    hit = 1'b0;
    d   = '0;
    idx = '0;
    if (wr_en && (wr_reg == rd)) begin
      hit = 1'b1;
      d   = wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && (entries[idx][EW-1:DW] == rd)) begin
        hit = 1'b1;
        d   = entries[idx][DW-1:0];
      end
    end
    if (rd == AW'(REG_ZERO)) begin
      hit = 1'b0;
      d   = '0;
    end
    return {hit, d};
  endfunction

  always_comb begin
    {fwd_hitA, fwd_dataA} = lookup(rd_regA);
    {fwd_hitB, fwd_dataB} = lookup(rd_regB);
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue: a queue-level model predicts
// occupancy, drain order and forwarding; a negedge monitor compares.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        rf_busy;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_regA;
  logic [4:0]  rd_regB;
  logic        fwd_hitA;
  logic        fwd_hitB;
  logic [31:0] fwd_dataA;
  logic [31:0] fwd_dataB;
  logic [2:0]  count;

  regfile_write_queue dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .rf_busy   (rf_busy),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .rd_regA   (rd_regA),
    .rd_regB   (rd_regB),
    .fwd_hitA  (fwd_hitA),
    .fwd_hitB  (fwd_hitB),
    .fwd_dataA (fwd_dataA),
    .fwd_dataB (fwd_dataB),
    .count     (count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  bit   rd_fixed = 0;
  ent_t mq[$];
  ent_t exp_q[$];
  ent_t m_out;
  bit   m_out_v = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  function automatic void fwd_model(input logic [4:0] rd,
                                    output logic hit,
                                    output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rd == 5'd0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].r == rd) begin
        hit = 1'b1;
        d   = mq[i].d;
        return;
      end
    end
    if (m_out_v && m_out.r == rd) begin
      hit = 1'b1;
      d   = m_out.d;
    end
  endfunction

  // Queue-level model: acceptance uses occupancy before this edge's pop.
  always @(posedge clk) begin
    bit   acc;
    bit   pp;
    ent_t e;
    if (!clr_n) begin
      mq.delete();
      exp_q.delete();
      m_out_v = 0;
      started = 1;
    end else if (started) begin
      acc = in_valid && (mq.size() < DEPTH);
      pp  = (mq.size() > 0) && !rf_busy;
      if (pp) begin
        m_out   = mq.pop_front();
        m_out_v = 1;
      end else begin
        m_out_v = 0;
      end
      if (acc && in_reg != 5'd0) begin
        e.r = in_reg;
        e.d = in_data;
        mq.push_back(e);
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    ent_t        e;
    logic        h;
    logic [31:0] d;
    if (started) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("wr_en", 32'(wr_en), 32'(m_out_v));
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow got write r%0d %h expected none",
                   wr_reg, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_reg", 32'(wr_reg), 32'(e.r));
          chk("wr_data", wr_data, e.d);
        end
      end
      fwd_model(rd_regA, h, d);
      chk("fwd_hitA", 32'(fwd_hitA), 32'(h));
      chk("fwd_dataA", fwd_dataA, d);
      fwd_model(rd_regB, h, d);
      chk("fwd_hitB", 32'(fwd_hitB), 32'(h));
      chk("fwd_dataB", fwd_dataB, d);
    end
  end

  task automatic drive(input logic v, input logic [4:0] r,
                       input logic [31:0] d, input logic b);
    in_valid = v;
    in_reg   = r;
    in_data  = d;
    rf_busy  = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rd_fixed) begin
      rd_regA = 5'($urandom_range(0, 7));
      rd_regB = 5'($urandom_range(0, 7));
    end
  endtask

  initial begin
    clr_n    = 1'b0;
    rd_fixed = 1;
    rd_regA  = 5'd5;
    rd_regB  = 5'd0;
    drive(1'b1, 5'd5, 32'h1234, 1'b0);
    step();
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_fwd_hitA", 32'(fwd_hitA), 0);
    clr_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    rd_fixed = 0;
    step();

    drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    step();
    chk("single_wr_en", 32'(wr_en), 1);
    chk("single_wr_reg", 32'(wr_reg), 3);
    chk("single_wr_data", wr_data, 32'hDEADBEEF);
    step();

    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 5'(i), 32'(i * 16'h1111), 1'b1);
      if (i == 5) begin
        chk("fill_in_ready", 32'(in_ready), 0);
        chk("fill_count", 32'(count), 4);
      end
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("drain_wr_en", 32'(wr_en), 1);
      chk("drain_wr_reg", 32'(wr_reg), 32'(k));
    end
    step();

    drive(1'b1, 5'd7, 32'd1, 1'b1);
    step();
    drive(1'b1, 5'd7, 32'd2, 1'b1);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    rd_fixed = 1;
    rd_regA  = 5'd7;
    #1;
    chk("prio_hitA", 32'(fwd_hitA), 1);
    chk("prio_dataA", fwd_dataA, 2);
    rf_busy = 1'b0;
    step();
    step();
    step();
    #1;
    chk("prio_drained_hitA", 32'(fwd_hitA), 0);
    rd_fixed = 0;

    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    chk("zero_in_ready", 32'(in_ready), 1);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    rd_fixed = 1;
    rd_regB  = 5'd0;
    #1;
    chk("zero_count", 32'(count), 0);
    chk("zero_hitB", 32'(fwd_hitB), 0);
    step();
    chk("zero_wr_en", 32'(wr_en), 0);
    rd_fixed = 0;

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'(i % 2));
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    repeat (8) step();

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 9), 32'(32'hA0 + i), 1'b1);
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    clr_n = 1'b0;
    step();
    chk("midrst_count", 32'(count), 0);
    chk("midrst_wr_en", 32'(wr_en), 0);
    clr_n   = 1'b1;
    rf_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_write", 32'(wr_en), 0);
    end

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom % 4 != 0), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom % 3 == 0));
      clr_n = ($urandom % 100 != 0);
      step();
    end
    clr_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    repeat (10) step();
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
